// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the single-clock programmable FIFO.
// Pointer/count width helper, default thresholds and the error-flag pair.
package sync_fifo_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_AFULL_MARGIN = 2;
  localparam int DEF_AEMPTY_TH    = 2;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: one write port, one read port.
// SYNC_FIFO_PROG_FWFT_EN selects an asynchronous read port; otherwise the read is registered.
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_PROG_FWFT_EN
  logic w_unused;
  assign w_unused = &{1'b0, re, rstn};
  assign rdata    = r_mem[raddr];
`else
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   r_rdata <= '0;
    else if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;
`endif

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, watermark flags, sticky error flags and flush.
// Define SYNC_FIFO_PROG_FWFT_EN for first-word-fall-through read data.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - DEF_AFULL_MARGIN,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   winc,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   rinc,
  output logic [WIDTH-1:0]       rdata,
  output logic                   wfull,
  output logic                   rempty,
  output logic                   walmost_full,
  output logic                   ralmost_empty,
  output logic [ptr_w(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  fifo_err_t     r_err;

  logic w_full, w_empty, w_wen, w_ren;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Flush wins over both requests; a full/empty side is simply refused.
  assign w_wen   = winc & ~w_full  & ~flush;
  assign w_ren   = rinc & ~w_empty & ~flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= '0;
    end else begin
      if (w_wen) r_wptr <= r_wptr + AW'(1);
      if (w_ren) r_rptr <= r_rptr + AW'(1);
      case ({w_wen, w_ren})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (winc & w_full)  r_err.overflow  <= 1'b1;
      if (rinc & w_empty) r_err.underflow <= 1'b1;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (w_wen),
    .waddr (r_wptr),
    .wdata (wdata),
    .re    (w_ren),
    .raddr (r_rptr),
    .rdata (rdata)
  );

  // Status decodes only from registered state.
  assign count         = r_count;
  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign walmost_full  = (r_count >= CW'(AFULL_TH));
  assign ralmost_empty = (r_count <= CW'(AEMPTY_TH));
  assign overflow      = r_err.overflow;
  assign underflow     = r_err.underflow;

endmodule
